// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter that sequences one APB bridge transfer at a time.
// Optional APB_ARB_TIMEOUT_EN aborts a transfer after TIMEOUT_CYCLES ISSUE/BUSY cycles.
module apb_req_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             req0,
    input  logic             req1,
    input  logic             rw0,
    input  logic             rw1,
    input  logic [WIDTH:0]   addr0,
    input  logic [WIDTH:0]   addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             transfer,
    output logic             read_write,
    output logic [WIDTH:0]   write_paddr,
    output logic [WIDTH:0]   read_paddr,
    output logic [WIDTH-1:0] write_data,
    input  logic             apb_done,
    input  logic             PSLVERR,
    input  logic [WIDTH-1:0] apb_rdata,
    output logic [1:0]       dbg_state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

    state_e           state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic             owner_q, owner_d;
    logic             rw_q, rw_d;
    logic [WIDTH:0]   addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             transfer_q, transfer_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             pick;
`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0]       cnt_q, cnt_d;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

    // Requesters hold req and fields stable from assertion until they sample
    // their done pulse; a req still high in the IDLE cycle after RESP is new.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        transfer_d = transfer_q;
        gnt_d      = gnt_q;
        done_d     = 2'b00;
        pick       = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Requester 1 wins when alone, or when both wait and 0 went last.
                    pick       = req1 && (!req0 || !last_gnt_q);
                    owner_d    = pick;
                    last_gnt_d = pick;
                    rw_d       = pick ? rw1 : rw0;
                    addr_d     = pick ? addr1 : addr0;
                    wdata_d    = pick ? wdata1 : wdata0;
                    gnt_d      = pick ? 2'b10 : 2'b01;
                    transfer_d = 1'b1;
                    state_d    = ISSUE;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end
            ISSUE, BUSY: begin
                state_d = BUSY;
                if (apb_done) begin
                    rdata_d    = rw_q ? '0 : apb_rdata;
                    err_d      = PSLVERR;
                    transfer_d = 1'b0;
                    done_d     = owner_q ? 2'b10 : 2'b01;
                    state_d    = RESP;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdata_d    = '0;
                    err_d      = 1'b1;
                    transfer_d = 1'b0;
                    done_d     = owner_q ? 2'b10 : 2'b01;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            transfer_q <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            transfer_q <= transfer_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign done0       = done_q[0];
    assign done1       = done_q[1];
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign transfer    = transfer_q;
    assign read_write  = rw_q;
    assign write_paddr = rw_q ? addr_q : '0;
    assign read_paddr  = rw_q ? '0 : addr_q;
    assign write_data  = rw_q ? wdata_q : '0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter; define APB_ARB_TIMEOUT_EN to add the timeout cases.
module tb_apb_req_arbiter;
    localparam int W = 32;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic         req0, req1, rw0, rw1;
    logic [W:0]   addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, done0, done1;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err, transfer, read_write;
    logic [W:0]   write_paddr, read_paddr;
    logic [W-1:0] write_data;
    logic         apb_done, PSLVERR;
    logic [W-1:0] apb_rdata;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    apb_req_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(5)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .transfer(transfer),
        .read_write(read_write), .write_paddr(write_paddr), .read_paddr(read_paddr),
        .write_data(write_data), .apb_done(apb_done), .PSLVERR(PSLVERR),
        .apb_rdata(apb_rdata), .dbg_state(dbg_state)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the ISSUE cycle.
    task automatic wait_gnt(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (gnt0 || gnt1) begin
                who = gnt1 ? 1 : 0;
                break;
            end
        end
        if (who < 0) check("gnt_seen", 64'(gnt0 | gnt1), 1);
    endtask

    // Drives apb_done in ISSUE/BUSY cycle number lat+1 (ISSUE is cycle 1).
    task automatic serve(input int lat, input logic [W-1:0] rd, input logic err);
        if (lat > 0) begin
            repeat (lat) @(posedge PCLK);
            #1;
        end
        check("xfer_held", 64'(transfer), 1);
        apb_done = 1'b1; apb_rdata = rd; PSLVERR = err;
        @(posedge PCLK); #1;
        apb_done = 1'b0; apb_rdata = '0; PSLVERR = 1'b0;
    endtask

    task automatic check_done(input int who, input logic [W-1:0] rd, input logic err);
        @(negedge PCLK);
        check("done0", 64'(done0), 64'(who == 0));
        check("done1", 64'(done1), 64'(who == 1));
        check("rsp_rdata", 64'(rsp_rdata), 64'(rd));
        check("rsp_err", 64'(rsp_err), 64'(err));
        check("xfer_drop", 64'(transfer), 0);
        check("gnt_hold", 64'(who == 1 ? gnt1 : gnt0), 1);
    endtask

    task automatic end_txn();
        @(posedge PCLK); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge PCLK);
        check("done_pulse", 64'({done1, done0}), 0);
        check("gnt_release", 64'({gnt1, gnt0}), 0);
        check("idle_state", 64'(dbg_state), 0);
    endtask

    initial begin
        int who;
        int n;
        PRESET = 1'b1;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        apb_done = 0; PSLVERR = 0; apb_rdata = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_gnt", 64'({gnt1, gnt0}), 0);
        check("rst_done", 64'({done1, done0}), 0);
        check("rst_xfer", 64'(transfer), 0);
        check("rst_wpaddr", 64'(write_paddr), 0);
        check("rst_rpaddr", 64'(read_paddr), 0);
        check("rst_wdata", 64'(write_data), 0);
        check("rst_rsp", 64'({rsp_err, rsp_rdata}), 0);
        check("rst_state", 64'(dbg_state), 0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // single write to slave1; requester 1 fields wiggle without effect
        req0 = 1; rw0 = 1; addr0 = 33'h1_0000_0010; wdata0 = 32'hDEAD_BEEF;
        wait_gnt(who);
        check("wr_who", 64'(who), 0);
        check("wr_state", 64'(dbg_state), 1);
        check("wr_rw", 64'(read_write), 1);
        check("wr_wpaddr", 64'(write_paddr), 64'h1_0000_0010);
        check("wr_rpaddr", 64'(read_paddr), 0);
        check("wr_wdata", 64'(write_data), 64'hDEAD_BEEF);
        addr1 = 33'h0_1234_5678; wdata1 = 32'h5555_5555;
        serve(3, 32'h1111_1111, 1'b0);
        check("wr_wpaddr_hold", 64'(write_paddr), 64'h1_0000_0010);
        check_done(0, 32'h0, 1'b0);
        end_txn();

        // read from slave2 by requester 1
        req1 = 1; rw1 = 0; addr1 = 33'h0_0000_0004; wdata1 = 32'h9999_9999;
        wait_gnt(who);
        check("rd_who", 64'(who), 1);
        check("rd_rw", 64'(read_write), 0);
        check("rd_rpaddr", 64'(read_paddr), 64'h0_0000_0004);
        check("rd_wpaddr", 64'(write_paddr), 0);
        check("rd_wdata", 64'(write_data), 0);
        serve(1, 32'hA5A5_A5A5, 1'b0);
        check_done(1, 32'hA5A5_A5A5, 1'b0);
        end_txn();

        // lone requester 1 again despite last grant; slave error
        req1 = 1; rw1 = 0; addr1 = 33'h1_0000_0020;
        wait_gnt(who);
        check("err_who", 64'(who), 1);
        check("err_rpaddr", 64'(read_paddr), 64'h1_0000_0020);
        serve(2, 32'h0BAD_F00D, 1'b1);
        check_done(1, 32'h0BAD_F00D, 1'b1);
        end_txn();

        // request that drops before any clock edge sees it
        req0 = 1; #2; req0 = 0;
        @(negedge PCLK);
        check("drop_gnt", 64'({gnt1, gnt0}), 0);
        check("drop_state", 64'(dbg_state), 0);

        // contention from reset
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        req0 = 1; rw0 = 1; addr0 = 33'h1_0000_0100; wdata0 = 32'h1111_2222;
        req1 = 1; rw1 = 0; addr1 = 33'h0_0000_0200;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(who);
            check("arb_order", 64'(who), 64'(k % 2));
            check("one_gnt", 64'(gnt0 & gnt1), 0);
            check("arb_addr", 64'(who == 0 ? write_paddr : read_paddr),
                  who == 0 ? 64'h1_0000_0100 : 64'h0_0000_0200);
            serve(1, 32'hC0DE_0000 + 32'(k), 1'b0);
            check_done(who, who == 0 ? 32'h0 : 32'hC0DE_0000 + 32'(k), 1'b0);
        end
        end_txn();

        // reset during BUSY aborts; the held req0 is then served
        req0 = 1; rw0 = 0; addr0 = 33'h0_0000_0008;
        wait_gnt(who);
        check("rb_who", 64'(who), 0);
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        check("rb_busy", 64'(dbg_state), 2);
        PRESET = 1'b1;
        #1;
        check("rb_xfer", 64'(transfer), 0);
        check("rb_gnt", 64'({gnt1, gnt0}), 0);
        check("rb_done", 64'({done1, done0}), 0);
        check("rb_rpaddr", 64'(read_paddr), 0);
        check("rb_state", 64'(dbg_state), 0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        wait_gnt(who);
        check("rb2_who", 64'(who), 0);
        check("rb2_rpaddr", 64'(read_paddr), 64'h0_0000_0008);
        serve(1, 32'h1234_5678, 1'b0);
        check_done(0, 32'h1234_5678, 1'b0);
        end_txn();

`ifdef APB_ARB_TIMEOUT_EN
        // no apb_done: transfer lasts exactly five cycles, then an error response
        req1 = 1; rw1 = 0; addr1 = 33'h0_0000_0010;
        wait_gnt(who);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (transfer) n++;
            else break;
        end
        check("to_len", 64'(n), 5);
        check("to_done1", 64'(done1), 1);
        check("to_err", 64'(rsp_err), 1);
        check("to_rdata", 64'(rsp_rdata), 0);
        end_txn();

        // apb_done on the terminal cycle takes priority
        req1 = 1; rw1 = 0; addr1 = 33'h0_0000_0014;
        wait_gnt(who);
        serve(4, 32'h7777_7777, 1'b0);
        check_done(1, 32'h7777_7777, 1'b0);
        end_txn();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
